// File: rtl/rtype_pkg.sv
// Shared definitions for the R-type issue controller: instruction layout,
// funct codes, FSM states, completion status codes and classification helpers.
package rtype_pkg;

   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;
   localparam int NREGS     = 32;

   localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;
   localparam logic [5:0] FUNCT_SLLV = 6'b000100;
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      READ = 2'b01,
      EXEC = 2'b10,
      WB   = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      ST_OK      = 2'b00,
      ST_ILLEGAL = 2'b01,
      ST_OVF     = 2'b10
   } status_t;

   typedef struct packed {
      logic [5:0]           opcode;
      logic [REG_IDX_W-1:0] rs;
      logic [REG_IDX_W-1:0] rt;
      logic [REG_IDX_W-1:0] rd;
      logic [4:0]           shamt;
      logic [5:0]           funct;
   } rinstr_t;

   function automatic logic is_legal(input rinstr_t i);
      logic ok;
      case (i.funct)
         FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV,
         FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT: ok = 1'b1;
         default:                                             ok = 1'b0;
      endcase
      return ok && (i.opcode == OPCODE_RTYPE);
   endfunction

   function automatic logic is_addsub(input rinstr_t i);
      return (i.funct == FUNCT_ADD) || (i.funct == FUNCT_SUB);
   endfunction

   // Illegal takes precedence; overflow only matters for add/sub.
   function automatic status_t wb_status(input logic legal, input logic addsub,
                                         input logic ovf);
      if (!legal)
         return ST_ILLEGAL;
      else if (addsub && ovf)
         return ST_OVF;
      else
         return ST_OK;
   endfunction

endpackage

// File: rtl/rtype_regfile.sv
// 32x32 register file: two operand read ports, one debug read port and a
// single write port shared by writeback and debug preload. $0 reads as zero.
module rtype_regfile
   import rtype_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] raddr_a,
   output logic [XLEN-1:0]      rdata_a,
   input  logic [REG_IDX_W-1:0] raddr_b,
   output logic [XLEN-1:0]      rdata_b,
   input  logic [REG_IDX_W-1:0] dbg_raddr,
   output logic [XLEN-1:0]      dbg_rdata,
   input  logic                 wb_we,
   input  logic [REG_IDX_W-1:0] wb_waddr,
   input  logic [XLEN-1:0]      wb_wdata,
   input  logic                 dbg_we,
   input  logic [REG_IDX_W-1:0] dbg_waddr,
   input  logic [XLEN-1:0]      dbg_wdata
);

   logic [XLEN-1:0]      regs [NREGS];
   logic                 we;
   logic [REG_IDX_W-1:0] waddr;
   logic [XLEN-1:0]      wdata;

   // Writeback and debug writes never coincide; writeback wins regardless.
   always_comb begin
      we    = wb_we | dbg_we;
      waddr = wb_we ? wb_waddr : dbg_waddr;
      wdata = wb_we ? wb_wdata : dbg_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (we && (waddr != '0)) begin
         regs[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_a   = (raddr_a   == '0) ? '0 : regs[raddr_a];
      rdata_b   = (raddr_b   == '0) ? '0 : regs[raddr_b];
      dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
   end

endmodule

// File: rtl/rtype_issue_ctrl.sv
// Four-cycle issue controller (IDLE/READ/EXEC/WB) driving an external
// combinational R-type ALU and writing its result back to the register file.
module rtype_issue_ctrl
   import rtype_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [31:0]          instr,
   output logic                 done,
   output logic [1:0]           done_status,
   output logic                 done_zero,
   output logic [5:0]           alu_funct,
   output logic [4:0]           alu_shamt,
   output logic [XLEN-1:0]      alu_a,
   output logic [XLEN-1:0]      alu_b,
   input  logic [XLEN-1:0]      alu_result,
   input  logic                 alu_zero,
   input  logic                 alu_overflow,
   input  logic                 dbg_we,
   input  logic [REG_IDX_W-1:0] dbg_waddr,
   input  logic [XLEN-1:0]      dbg_wdata,
   input  logic [REG_IDX_W-1:0] dbg_raddr,
   output logic [XLEN-1:0]      dbg_rdata
);

   state_t          state_q, state_d;
   rinstr_t         instr_q;
   logic            legal_q, addsub_q;
   logic            zero_q, ovf_q;
   logic [XLEN-1:0] res_q;
   logic [XLEN-1:0] rs_data, rt_data;
   logic            accept;
   logic            wb_we;
   logic            dbg_we_idle;
   status_t         status;

   assign accept      = instr_valid & instr_ready;
   assign dbg_we_idle = dbg_we & (state_q == IDLE);

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = READ;
         READ:    state_d = EXEC;
         EXEC:    state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // done is masked during reset so an abandoned WB never reports completion.
   always_comb begin
      instr_ready = (state_q == IDLE);
      status      = wb_status(legal_q, addsub_q, ovf_q);
      done        = (state_q == WB) && !reset;
      done_status = done ? status : ST_OK;
      done_zero   = done ? zero_q : 1'b0;
      wb_we       = done && (status == ST_OK);
   end

   // IDLE: capture instruction on accept
   always_ff @(posedge clk) begin
      if (state_q == IDLE && accept)
         instr_q <= rinstr_t'(instr);
   end

   // READ: operands and decode registered toward the ALU
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_funct <= '0;
         alu_shamt <= '0;
         legal_q   <= 1'b0;
         addsub_q  <= 1'b0;
      end else if (state_q == READ) begin
         alu_a     <= rs_data;
         alu_b     <= rt_data;
         alu_funct <= instr_q.funct;
         alu_shamt <= instr_q.shamt;
         legal_q   <= is_legal(instr_q);
         addsub_q  <= is_addsub(instr_q);
      end
   end

   // EXEC: ALU outputs sampled at end of cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state_q == EXEC) begin
         zero_q <= alu_zero;
         ovf_q  <= alu_overflow;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == EXEC)
         res_q <= alu_result;
   end

   rtype_regfile u_regfile (
      .clk       (clk),
      .reset     (reset),
      .raddr_a   (instr_q.rs),
      .rdata_a   (rs_data),
      .raddr_b   (instr_q.rt),
      .rdata_b   (rt_data),
      .dbg_raddr (dbg_raddr),
      .dbg_rdata (dbg_rdata),
      .wb_we     (wb_we),
      .wb_waddr  (instr_q.rd),
      .wb_wdata  (res_q),
      .dbg_we    (dbg_we_idle),
      .dbg_waddr (dbg_waddr),
      .dbg_wdata (dbg_wdata)
   );

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Directed bench for rtype_issue_ctrl with a behavioural R-type ALU model
// attached to the alu_* interface.
module tb_rtype_issue_ctrl;
   import rtype_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic        done;
   logic [1:0]  done_status;
   logic        done_zero;
   logic [5:0]  alu_funct;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_a, alu_b;
   logic [31:0] alu_result;
   logic        alu_zero;
   logic        alu_overflow;
   logic        dbg_we;
   logic [4:0]  dbg_waddr;
   logic [31:0] dbg_wdata;
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;

   int n_cmp = 0;
   int n_err = 0;
   int lat;
   logic       seen_done;
   logic [1:0] d_status;
   logic       d_zero;
   logic [4:0] d_shamt;

   always #5 clk = ~clk;

   rtype_issue_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .done         (done),
      .done_status  (done_status),
      .done_zero    (done_zero),
      .alu_funct    (alu_funct),
      .alu_shamt    (alu_shamt),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .dbg_we       (dbg_we),
      .dbg_waddr    (dbg_waddr),
      .dbg_wdata    (dbg_wdata),
      .dbg_raddr    (dbg_raddr),
      .dbg_rdata    (dbg_rdata)
   );

   // Reference ALU
   always_comb begin
      alu_overflow = 1'b0;
      case (alu_funct)
         FUNCT_SLL:  alu_result = alu_b << alu_shamt;
         FUNCT_SRL:  alu_result = alu_b >> alu_shamt;
         FUNCT_SRA:  alu_result = $unsigned($signed(alu_b) >>> alu_shamt);
         FUNCT_SLLV: alu_result = alu_b << alu_a[4:0];
         FUNCT_ADD: begin
            alu_result   = alu_a + alu_b;
            alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         FUNCT_SUB: begin
            alu_result   = alu_a - alu_b;
            alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
         end
         FUNCT_AND:  alu_result = alu_a & alu_b;
         FUNCT_OR:   alu_result = alu_a | alu_b;
         FUNCT_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default:    alu_result = 32'd0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      dbg_raddr = a;
      #1;
      chk(tag, dbg_rdata, exp);
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
      @(negedge clk);
      dbg_we = 1'b0;
   endtask

   // Offer one instruction, return latency from accept edge to done.
   // With poke set, a debug write to $6 is attempted during READ.
   task automatic issue(input logic [31:0] ins, input bit poke);
      int k;
      instr = ins; instr_valid = 1'b1;
      k = 0;
      while (!instr_ready && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      instr_valid = 1'b0;
      if (poke) begin dbg_we = 1'b1; dbg_waddr = 5'd6; dbg_wdata = 32'hAAAA_AAAA; end
      lat = 1;
      while (!done && lat < 10) begin
         @(negedge clk);
         dbg_we = 1'b0;
         lat++;
      end
      dbg_we    = 1'b0;
      seen_done = done;
      d_status  = done_status;
      d_zero    = done_zero;
      d_shamt   = alu_shamt;
      @(negedge clk);
   endtask

   initial begin
      int acc, dn;
      reset = 1'b1; instr_valid = 1'b0; instr = '0;
      dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0; dbg_raddr = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(instr_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_status", 32'(done_status), 32'd0);
      chk("rst_zero", 32'(done_zero), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_funct", 32'(alu_funct), 32'd0);
      chk("rst_shamt", 32'(alu_shamt), 32'd0);
      reg_chk("rst_r5", 5'd5, 32'd0);

      // add $3,$1,$2 = 12
      preload(5'd1, 32'd5); preload(5'd2, 32'd7);
      issue(32'h0022_1820, 1'b0);
      chk("add_seen", 32'(seen_done), 32'd1);
      chk("add_lat", 32'(lat), 32'd3);
      chk("add_status", 32'(d_status), 32'd0);
      chk("add_zero", 32'(d_zero), 32'd0);
      reg_chk("add_r3", 5'd3, 32'd12);
      chk("post_done_ready", 32'(instr_ready), 32'd1);

      // sll $5,$2,4
      preload(5'd2, 32'h0000_000F);
      issue(32'h0002_2900, 1'b0);
      chk("sll_shamt", 32'(d_shamt), 32'd4);
      chk("sll_status", 32'(d_status), 32'd0);
      reg_chk("sll_r5", 5'd5, 32'h0000_00F0);

      // add overflow leaves $3 alone
      preload(5'd1, 32'h7FFF_FFFF); preload(5'd2, 32'd1);
      issue(32'h0022_1820, 1'b0);
      chk("ovf_status", 32'(d_status), 32'd2);
      reg_chk("ovf_r3", 5'd3, 32'd12);

      // illegal opcode, plus debug write attempt outside IDLE
      preload(5'd6, 32'h0000_0055);
      issue(32'h2001_0005, 1'b1);
      chk("ill_lat", 32'(lat), 32'd3);
      chk("ill_status", 32'(d_status), 32'd1);
      reg_chk("ill_r1", 5'd1, 32'h7FFF_FFFF);
      reg_chk("ill_r3", 5'd3, 32'd12);
      reg_chk("dbg_busy_r6", 5'd6, 32'h0000_0055);

      // sub $4,$1,$2 -> zero
      preload(5'd1, 32'd9); preload(5'd2, 32'd9);
      preload(5'd4, 32'h1234_5678);
      issue(32'h0022_2022, 1'b0);
      chk("sub_status", 32'(d_status), 32'd0);
      chk("sub_zero", 32'(d_zero), 32'd1);
      reg_chk("sub_r4", 5'd4, 32'd0);

      // writes to $0 are dropped
      issue(32'h0022_0020, 1'b0);
      chk("r0_status", 32'(d_status), 32'd0);
      reg_chk("r0_wb", 5'd0, 32'd0);
      preload(5'd0, 32'hDEAD_BEEF);
      reg_chk("r0_dbg", 5'd0, 32'd0);

      // reset during EXEC abandons the instruction
      preload(5'd1, 32'd5); preload(5'd2, 32'd7);
      instr = 32'h0022_1820; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rstx_done_in_rst", 32'(done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rstx_ready", 32'(instr_ready), 32'd1);
      dn = 0;
      for (int i = 0; i < 4; i++) begin
         if (done) dn++;
         @(negedge clk);
      end
      chk("rstx_no_done", 32'(dn), 32'd0);
      reg_chk("rstx_r3", 5'd3, 32'd0);

      // continuous valid: one accept per four cycles
      preload(5'd1, 32'd5); preload(5'd2, 32'd7);
      instr = 32'h0022_3820; instr_valid = 1'b1;
      acc = 0; dn = 0;
      for (int i = 0; i < 12; i++) begin
         if (instr_ready && instr_valid) acc++;
         if (done) dn++;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (done) dn++;
         @(negedge clk);
      end
      chk("hold_accepts", 32'(acc), 32'd3);
      chk("hold_dones", 32'(dn), 32'd3);
      reg_chk("hold_r7", 5'd7, 32'd12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
